online_ccm_sched: RTL and testbench
===================================

Name: online_ccm_sched

Overview:
- Sequencer that time-shares one combinational online constant-coefficient multiplier (redundant-digit CCM, 2 bits per digit) among NREQ requesters, such as Butterworth filter taps.
- Latches the winning operand into the CCM input register and waits a runtime-programmable number of settle cycles. It then samples the CCM output into a result register and returns the result with the requester ID.
- The programmable settle count lets the overclocking test platform sweep sampling time against CCM propagation delay.

Parameters:
- STAGE, 4, CCM input digit count; operand width WL=2*STAGE bits.
- OUT_W, 28, CCM output width in bits (2*(STAGE+10) for the 178 CCM family).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; ceil(log2(NREQ)), minimum 1.
- SETW, 4, width of the settle-count field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_x  in  NREQ*WL  packed operands; requester i occupies bits [i*WL +: WL]
- req_ready  out  NREQ  one-hot grant/accept pulse
- settle_cycles  in  SETW  cycles from launch to capture; 0 is treated as 1
- ccm_x  out  WL  registered operand driven to the CCM
- ccm_y  in  OUT_W  CCM combinational result
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_y  out  OUT_W  captured result
- resp_id  out  IDW  index of the requester that owns resp_y
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset state: IDLE. Reset values: req_ready=0, ccm_x=0, resp_valid=0, resp_y=0, resp_id=0, busy=0, rr_ptr=0, settle counter=0.
- Reset is asynchronous. Asserting rst_n low mid-operation aborts the operation: no response is produced and the pending operand is lost.
- Arbitration is round-robin. Search starts at rr_ptr and wraps modulo NREQ. The first requester with req_valid=1 wins. After a grant, rr_ptr = winner+1 (mod NREQ).
- IDLE: if any req_valid is high, in the same cycle:
  - assert req_ready[winner] combinationally for one cycle;
  - on the clock edge: ccm_x <= req_x[winner]; id_q <= winner; cnt <= max(settle_cycles,1); move to SETTLE.
  - settle_cycles is sampled only at this point; later changes do not affect the operation in flight.
- SETTLE: cnt decrements each cycle. When cnt==1: resp_y <= ccm_y, resp_id <= id_q, resp_valid <= 1; move to RESP.
- Latency: capture happens on the settle_cycles-th edge after the launch edge. resp_valid rises in that same edge, i.e. settle_cycles+1 cycles after the grant cycle.
- RESP: hold resp_valid, resp_y and resp_id stable until resp_valid && resp_ready.
  - On that handshake: clear resp_valid.
  - If any req_valid is high in the handshake cycle, grant immediately (back-to-back, same behaviour as IDLE). Otherwise go to IDLE.
- req_ready is never asserted in SETTLE, or in RESP without the handshake. Requesters must hold req_valid and req_x stable until granted.
- req_ready is one-hot or zero in every cycle.
- A requester that drops req_valid before being granted is simply skipped.
- Arithmetic: no arithmetic in this block. ccm_y is passed through unmodified at full OUT_W width. The ID is carried unchanged.
- ccm_x is held from launch until the next grant, so the CCM inputs never toggle during settle.

Decomposition:
- Shared package online_pkg holds:
  - state encoding (IDLE, SETTLE, RESP);
  - the WL and OUT_W derivation functions;
  - a clog2 helper.
- One natural sub-module: rr_arbiter (NREQ request vector plus pointer in; one-hot grant and encoded winner out; combinational).
- The FSM, counter and result registers stay in online_ccm_sched.

Test Plan:
- Single request: req_valid=0001, req_x=8'h5A, settle_cycles=3, CCM model y=178*x.
  - Expect req_ready=0001 for one cycle and ccm_x=5A after the edge.
  - Expect resp_valid rising 4 cycles after the grant cycle, with resp_y=model(5A) and resp_id=0.
- Round-robin fairness: all four requesters held valid, resp_ready=1, settle_cycles=1.
  - Expect grant order 0,1,2,3,0, with a new grant in every RESP handshake cycle.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid.
  - Expect resp_y and resp_id stable, no req_ready asserted, and ccm_x unchanged.
  - Then resp_ready=1: expect one handshake and the next grant.
- Settle edge cases:
  - settle_cycles=0 must behave exactly like 1.
  - settle_cycles=15: capture on the 15th edge. Change settle_cycles mid-SETTLE and confirm the latency is unchanged.
  - Deliberately slow CCM model (output valid only after 3 cycles) with settle=2: expect the stale value captured, i.e. sampling point verified.
- Reset mid-SETTLE: assert rst_n low for 1 cycle during SETTLE.
  - Expect all outputs at reset values immediately (asynchronous), no response, rr_ptr=0, and the next grant going to requester 0.
- Sparse/withdrawn request: req_valid=0100 with rr_ptr=3; requester 1 raises then drops valid before service.
  - Expect the wrap-around search to grant 2, requester 1 never granted, and no X on resp_id.

Source files
------------

// File: rtl/online_pkg.sv
// Shared definitions for the online CCM sequencer: FSM state encoding and width helpers.
package online_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic int calc_wl(input int stage);
    return 2 * stage;
  endfunction

  // Output width of the 178 CCM family for a given input digit count.
  function automatic int calc_out_w(input int stage);
    return 2 * (stage + 10);
  endfunction

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/online_ccm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i upward, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  win_o,
  output logic            any_o
);

  logic [IDW-1:0] idx_s;
  logic           found_s;

  // First requesting index at or after the pointer wins.
  always_comb begin
    gnt_o   = {NREQ{1'b0}};
    win_o   = {IDW{1'b0}};
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found_s && req_i[idx_s]) begin
        found_s      = 1'b1;
        gnt_o[idx_s] = 1'b1;
        win_o        = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/online_ccm_sched.sv
// Time-shares one combinational online CCM among NREQ requesters with a programmable
// settle window between operand launch and result capture.
module online_ccm_sched
  import online_pkg::*;
#(
  parameter int STAGE = 4,
  parameter int OUT_W = 28,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int SETW  = 4,
  localparam int WL   = calc_wl(STAGE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WL-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  input  logic [SETW-1:0]      settle_cycles,
  output logic [WL-1:0]        ccm_x,
  input  logic [OUT_W-1:0]     ccm_y,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [OUT_W-1:0]     resp_y,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  state_e           state_q, state_d;
  logic [SETW-1:0]  cnt_q, cnt_d;
  logic [WL-1:0]    ccm_x_q, ccm_x_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [OUT_W-1:0] resp_y_q, resp_y_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  arb_gnt_s;
  logic [IDW-1:0]   arb_win_s;
  logic             arb_any_s;
  logic             grant_en_s;
  logic [WL-1:0]    operand_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_s),
    .win_o (arb_win_s),
    .any_o (arb_any_s)
  );

  // A grant is only possible from IDLE or in the RESP handshake cycle.
  always_comb begin
    case (state_q)
      ST_IDLE: grant_en_s = arb_any_s;
      ST_RESP: grant_en_s = arb_any_s & resp_ready;
      default: grant_en_s = 1'b0;
    endcase
  end

  always_comb begin
    operand_s = {WL{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (arb_win_s == IDW'(i)) begin
        operand_s = req_x[i*WL +: WL];
      end else begin
        operand_s = operand_s;
      end
    end
  end

  // Gated with rst_n so no grant leaks out while reset is held.
  assign req_ready = (grant_en_s && rst_n) ? arb_gnt_s : {NREQ{1'b0}};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ccm_x_d      = ccm_x_q;
    id_d         = id_q;
    resp_y_d     = resp_y_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= SETW'(1)) begin
          resp_y_d     = ccm_y;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          cnt_d        = {SETW{1'b0}};
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - SETW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Launch overrides the per-state next state; settle_cycles is sampled only here.
    if (grant_en_s) begin
      ccm_x_d  = operand_s;
      id_d     = arb_win_s;
      cnt_d    = (settle_cycles == {SETW{1'b0}}) ? SETW'(1) : settle_cycles;
      rr_ptr_d = (arb_win_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : arb_win_s + IDW'(1);
      state_d  = ST_SETTLE;
    end else begin
      rr_ptr_d = rr_ptr_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {SETW{1'b0}};
      ccm_x_q      <= {WL{1'b0}};
      id_q         <= {IDW{1'b0}};
      resp_y_q     <= {OUT_W{1'b0}};
      resp_id_q    <= {IDW{1'b0}};
      resp_valid_q <= 1'b0;
      rr_ptr_q     <= {IDW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ccm_x_q      <= ccm_x_d;
      id_q         <= id_d;
      resp_y_q     <= resp_y_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
    end
  end

  assign ccm_x      = ccm_x_q;
  assign resp_y     = resp_y_q;
  assign resp_id    = resp_id_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_online_ccm_sched.sv
// Self-checking bench for online_ccm_sched: vector table, directed corner sequences and
// randomized operations against a round-robin reference model with a y=178*x CCM.
module tb_online_ccm_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [3:0]  req_ready;
  logic [3:0]  settle_cycles;
  logic [7:0]  ccm_x;
  logic [27:0] ccm_y;
  logic        resp_valid;
  logic        resp_ready;
  logic [27:0] resp_y;
  logic [1:0]  resp_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  logic       slow_mode = 1'b0;
  logic [7:0] cur_x = 8'h00;
  logic [7:0] old_x = 8'h00;
  int         age = 0;

  online_ccm_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_ready     (req_ready),
    .settle_cycles (settle_cycles),
    .ccm_x         (ccm_x),
    .ccm_y         (ccm_y),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_y        (resp_y),
    .resp_id       (resp_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] ccm_model(input logic [7:0] x);
    return 28'(32'd178 * {24'd0, x});
  endfunction

  // Slow CCM: after ccm_x changes, the old product persists for 3 cycles.
  always @(ccm_x or negedge clk) begin
    if (ccm_x !== cur_x) begin
      old_x = cur_x;
      cur_x = ccm_x;
      age   = 0;
    end else if (clk == 1'b0) begin
      age = age + 1;
    end
  end
  assign ccm_y = ccm_model((slow_mode && age < 3) ? old_x : ccm_x);

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] valid, input logic [31:0] xs, input logic [3:0] settle,
                        input int stall, input logic [3:0] side, input logic [1:0] exp_id,
                        input logic [7:0] exp_x, input logic [27:0] exp_y);
    int n;
    n = (settle == 4'd0) ? 1 : int'(settle);
    @(negedge clk);
    req_valid = valid; req_x = xs; settle_cycles = settle; resp_ready = 1'b0;
    #1;
    check("grant", 64'(req_ready), 64'(4'(4'b0001 << exp_id)));
    check("busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = side;
    settle_cycles = ~settle;
    check("ccm_x_launch", 64'(ccm_x), 64'(exp_x));
    check("busy_settle", 64'(busy), 64'd1);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      if (e < n) begin
        check("early_resp", 64'(resp_valid), 64'd0);
        check("settle_ready", 64'(req_ready), 64'd0);
      end else begin
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_y", 64'(resp_y), 64'(exp_y));
        check("resp_id", 64'(resp_id), 64'(exp_id));
        check("resp_id_known", 64'($isunknown(resp_id)), 64'd0);
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_y", 64'(resp_y), 64'(exp_y));
      check("stall_id", 64'(resp_id), 64'(exp_id));
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_ccm_x", 64'(ccm_x), 64'(exp_x));
    end
    @(negedge clk);
    req_valid = 4'b0000; resp_ready = 1'b1;
    #1;
    check("hs_no_grant", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("hs_cleared", 64'(resp_valid), 64'd0);
    check("hs_idle", 64'(busy), 64'd0);
    m_ptr = (int'(exp_id) + 1) % 4;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] xs;
    logic [3:0]  settle;
    int          stall;
    logic [3:0]  side;
    logic [1:0]  exp_id;
    logic [7:0]  exp_x;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int ngr;
    int g;
    int w;
    logic [3:0]  rv;
    logic [31:0] rx;

    // Expected ids assume the pointer sequence 0,1,2,1,0,0,2,3,3 from reset.
    tbl[0] = '{4'b0001, 32'h0000005A, 4'd3,  0, 4'b0000, 2'd0, 8'h5A};
    tbl[1] = '{4'b1111, 32'hC3A57F10, 4'd1,  0, 4'b0000, 2'd1, 8'h7F};
    tbl[2] = '{4'b0001, 32'h000000FF, 4'd0,  0, 4'b0000, 2'd0, 8'hFF};
    tbl[3] = '{4'b1001, 32'h80000001, 4'd2,  5, 4'b0110, 2'd3, 8'h80};
    tbl[4] = '{4'b1000, 32'h11000000, 4'd15, 0, 4'b0000, 2'd3, 8'h11};
    tbl[5] = '{4'b0110, 32'h00E73C00, 4'd4,  2, 4'b0000, 2'd1, 8'h3C};
    tbl[6] = '{4'b0100, 32'h00990000, 4'd1,  0, 4'b0000, 2'd2, 8'h99};
    tbl[7] = '{4'b0100, 32'h00420000, 4'd3,  3, 4'b0010, 2'd2, 8'h42};
    tbl[8] = '{4'b0011, 32'h0000BEEF, 4'd2,  0, 4'b0000, 2'd0, 8'hEF};

    rst_n = 1'b0; req_valid = 4'b0000; req_x = 32'h0; settle_cycles = 4'd0; resp_ready = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_ccm_x", 64'(ccm_x), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_y", 64'(resp_y), 64'd0);
    check("rst_id", 64'(resp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].valid, tbl[i].xs, tbl[i].settle, tbl[i].stall, tbl[i].side,
             tbl[i].exp_id, tbl[i].exp_x, ccm_model(tbl[i].exp_x));
    end

    // Slow CCM with settle=2 must capture the product of the previous operand (EF).
    slow_mode = 1'b1;
    run_op(4'b0001, 32'h00000033, 4'd2, 0, 4'b0000, 2'd0, 8'h33, ccm_model(8'hEF));
    slow_mode = 1'b0;

    // Reset mid-SETTLE: operand lost, pointer back to 0.
    @(negedge clk);
    req_valid = 4'b0010; req_x = 32'h00007700; settle_cycles = 4'd10;
    #1;
    check("pre_rst_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111; req_x = 32'h44332211; settle_cycles = 4'd1;
    #1;
    check("arst_ready", 64'(req_ready), 64'd0);
    check("arst_ccm_x", 64'(ccm_x), 64'd0);
    check("arst_valid", 64'(resp_valid), 64'd0);
    check("arst_y", 64'(resp_y), 64'd0);
    check("arst_id", 64'(resp_id), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'b0001);
    req_valid = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("aborted_no_resp", 64'(resp_valid), 64'd0);
    end
    m_ptr = 0;

    // Round-robin fairness with back-to-back grants in every handshake cycle.
    @(negedge clk);
    req_valid = 4'b1111; req_x = 32'h44332211; settle_cycles = 4'd1; resp_ready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 30 && ngr < 5; c++) begin
      #1;
      if (resp_valid) begin
        check("rr_b2b", 64'(req_ready != 4'b0000), 64'd1);
        check("rr_resp_id", 64'(resp_id), 64'((ngr - 1) % 4));
        check("rr_resp_y", 64'(resp_y), 64'(ccm_model(8'(req_x >> (8 * ((ngr - 1) % 4))))));
      end
      if (req_ready != 4'b0000) begin
        check("rr_onehot", 64'($countones(req_ready)), 64'd1);
        g = 0;
        for (int b = 0; b < 4; b++) if (req_ready[b]) g = b;
        check("rr_order", 64'(g), 64'(ngr % 4));
        ngr++;
      end
      @(negedge clk);
    end
    check("rr_grant_count", 64'(ngr), 64'd5);
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    check("rr_drain_busy", 64'(busy), 64'd0);
    check("rr_drain_valid", 64'(resp_valid), 64'd0);
    resp_ready = 1'b0;
    m_ptr = 1;

    for (int r = 0; r < 40; r++) begin
      rv = 4'($urandom_range(1, 15));
      rx = $urandom;
      w  = pick(rv, m_ptr);
      run_op(rv, rx, 4'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 4'b0000,
             2'(w), 8'(rx >> (8 * w)), ccm_model(8'(rx >> (8 * w))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
